// File: rtl/multdiv_ctrl.sv
// HI/LO multiply/divide controller: latency-counted multiplier plus radix-2 restoring divider.
// Optional MULTDIV_DIV_EARLY_OUT_EN skips divider iterations when |a|<|b| or b==0.
module multdiv_ctrl #(
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_acc_q, hi_acc_d, lo_acc_q, lo_acc_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        launch, op_i_is_div, op_i_div_signed;
  logic        div_signed, mul_signed, b_zero, early_out;
  logic [63:0] a_ext, b_ext, prod, acc, mul_res;
  logic [31:0] a_mag, dvs_mag, a_i_mag;
  logic [32:0] shifted, diff;
  logic        q_bit;
  logic [31:0] rem_step, quo_step, rem_fix, quo_fix;

  assign launch          = (state_q == S_IDLE) && valid_i && !flush_i;
  assign op_i_is_div     = (op_i == 3'd2) || (op_i == 3'd3);
  assign op_i_div_signed = (op_i == 3'd2);
  assign a_i_mag         = (op_i_div_signed && a_i[31]) ? -a_i : a_i;

  // Sign-extending to 64 bits lets one unsigned multiply serve both signednesses.
  assign mul_signed = ~op_q[0];
  assign a_ext      = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign b_ext      = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod       = a_ext * b_ext;
  assign acc        = {hi_acc_q, lo_acc_q};
  assign mul_res    = op_q[2] ? (op_q[1] ? acc - prod : acc + prod) : prod;

  assign div_signed = (op_q == 3'd2);
  assign b_zero     = (b_q == 32'd0);
  assign a_mag      = (div_signed && a_q[31]) ? -a_q : a_q;
  assign dvs_mag    = (div_signed && b_q[31]) ? -b_q : b_q;

  // quo_q starts as the dividend magnitude and fills with quotient bits from the right.
  assign shifted  = {rem_q, quo_q[31]};
  assign diff     = shifted - {1'b0, dvs_mag};
  assign q_bit    = ~diff[32];
  assign rem_step = q_bit ? diff[31:0] : shifted[31:0];
  assign quo_step = {quo_q[30:0], q_bit};
  assign quo_fix  = (div_signed && (a_q[31] ^ b_q[31])) ? -quo_step : quo_step;
  assign rem_fix  = (div_signed && a_q[31]) ? -rem_step : rem_step;

`ifdef MULTDIV_DIV_EARLY_OUT_EN
  assign early_out = (cnt_q == 5'd0) && (b_zero || (a_mag < dvs_mag));
`else
  assign early_out = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_acc_d = hi_acc_q;
    lo_acc_d = lo_acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    stall_o  = 1'b0;
    done_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          stall_o  = 1'b1;
          op_d     = op_i;
          a_d      = a_i;
          b_d      = b_i;
          hi_acc_d = hi_i;
          lo_acc_d = lo_i;
          rem_d    = 32'd0;
          quo_d    = a_i_mag;
          cnt_d    = 5'd0;
          state_d  = op_i_is_div ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        stall_o = 1'b1;
        if (cnt_q == 5'(MUL_LAT - 1)) begin
          state_d      = S_DONE;
          {hi_d, lo_d} = mul_res;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DIV: begin
        stall_o = 1'b1;
        if (early_out) begin
          state_d = S_DONE;
          hi_d    = a_q;
          lo_d    = b_zero ? 32'hFFFF_FFFF : 32'd0;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          if (cnt_q == 5'(DIV_ITERS - 1)) begin
            state_d = S_DONE;
            // Division by zero reports all-ones quotient and the raw dividend.
            hi_d    = b_zero ? a_q : rem_fix;
            lo_d    = b_zero ? 32'hFFFF_FFFF : quo_fix;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A flush abandons whatever is in flight and leaves the visible HI/LO untouched.
    if (flush_i) begin
      state_d = S_IDLE;
      stall_o = 1'b0;
      done_o  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      hi_acc_q <= 32'd0;
      lo_acc_q <= 32'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_acc_q <= hi_acc_d;
      lo_acc_q <= lo_acc_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: vector table plus flush/reset corner sequences.
module tb_multdiv_ctrl;

  localparam int MUL_LAT = 3;
`ifdef MULTDIV_DIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] a_i = 32'd0, b_i = 32'd0, hi_i = 32'd0, lo_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        stall_o, done_o;
  logic [31:0] hi_o, lo_o;

  int n_applied = 0;
  int n_miscompares = 0;

  multdiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITERS(32)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .hi_i(hi_i), .lo_i(lo_i), .flush_i(flush_i),
    .stall_o(stall_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [31:0] exp_hi, exp_lo;
    bit          early;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input vec_t v);
    if (v.op == 3'd2 || v.op == 3'd3)
      return (EARLY_EN && v.early) ? 2 : 33;
    return MUL_LAT + 1;
  endfunction

  // Launch one op, hold valid_i high through DONE, then check one-pulse behaviour.
  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    bit stall_ok;
    @(negedge clk);
    op_i = v.op; a_i = v.a; b_i = v.b; hi_i = v.hi; lo_i = v.lo; valid_i = 1'b1;
    #1 stall_ok = (stall_o === 1'b1);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        lat = k;
        break;
      end
      if (stall_o !== 1'b1) stall_ok = 1'b0;
    end
    if (stall_o !== 1'b0) stall_ok = 1'b0;
    check($sformatf("v%0d latency", idx), 64'(lat), 64'(exp_latency(v)));
    check($sformatf("v%0d stall", idx), 64'(stall_ok), 64'd1);
    check($sformatf("v%0d hi", idx), 64'(hi_o), 64'(v.exp_hi));
    check($sformatf("v%0d lo", idx), 64'(lo_o), 64'(v.exp_lo));
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d single pulse", idx), 64'({done_o, stall_o}), 64'd0);
    $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", idx, v.op, v.a, v.b, hi_o, lo_o, lat);
  endtask

  initial begin
    vec_t mv;
    int dcount;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,         32'd0, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
    vecs[1]  = '{3'd5, 32'd1,         32'd1,         32'd0, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
    vecs[2]  = '{3'd6, 32'd1,         32'd1,         32'd0, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'd0, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{3'd3, 32'd100,       32'd0,         32'd0, 32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0,         32'd0,         32'h8000_0000, 1'b0};
    vecs[6]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,         32'hFFFF_FFFE, 32'd1,         1'b0};
    vecs[7]  = '{3'd3, 32'd10,        32'd3,         32'd0, 32'd0,         32'd1,         32'd3,         1'b0};
    vecs[8]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd0, 32'd0,         32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{3'd3, 32'd3,         32'd10,        32'd0, 32'd0,         32'd3,         32'd0,         1'b1};
    vecs[10] = '{3'd2, 32'hFFFF_FFFD, 32'd10,        32'd0, 32'd0,         32'hFFFF_FFFD, 32'd0,         1'b1};
    vecs[11] = '{3'd4, 32'hFFFF_FFFF, 32'd2,         32'd0, 32'd5,         32'd0,         32'd3,         1'b0};
    vecs[12] = '{3'd7, 32'd1,         32'd1,         32'd0, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[13] = '{3'd2, 32'hFFFF_FFF8, 32'd0,         32'd0, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
    vecs[14] = '{3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd0,         32'hC000_0000, 32'h8000_0000, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset outputs", {30'd0, stall_o, done_o, hi_o}, 64'd0);
    check("reset lo", 64'(lo_o), 64'd0);

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Flush a DIVU in cycle 10: nothing completes and HI/LO keep the last result.
    @(negedge clk);
    op_i = 3'd3; a_i = 32'd10; b_i = 32'd3; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    flush_i = 1'b1;
    #1 check("flush stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    flush_i = 1'b0;
    check("post-flush stall/done", 64'({stall_o, done_o}), 64'd0);
    check("post-flush hi", 64'(hi_o), 64'(vecs[14].exp_hi));
    check("post-flush lo", 64'(lo_o), 64'(vecs[14].exp_lo));
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_o === 1'b1) dcount++;
    end
    check("flush no done", 64'(dcount), 64'd0);
    $display("flush sequence: hi=%h lo=%h done pulses=%0d", hi_o, lo_o, dcount);

    mv = '{3'd1, 32'd5, 32'd6, 32'd0, 32'd0, 32'd0, 32'd30, 1'b0};
    run_vec(15, mv);

    // Reset asserted in cycle 5 of a DIV clears everything by cycle 6.
    @(negedge clk);
    op_i = 3'd2; a_i = 32'd100; b_i = 32'd7; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid-div reset stall/done", 64'({stall_o, done_o}), 64'd0);
    check("mid-div reset hi", 64'(hi_o), 64'd0);
    check("mid-div reset lo", 64'(lo_o), 64'd0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_o === 1'b1) dcount++;
    end
    check("reset no done", 64'(dcount), 64'd0);
    $display("reset sequence: hi=%h lo=%h done pulses=%0d", hi_o, lo_o, dcount);

    // Flush coinciding with a launch request suppresses the launch.
    @(negedge clk);
    op_i = 3'd1; a_i = 32'd5; b_i = 32'd6; valid_i = 1'b1; flush_i = 1'b1;
    #1 check("flush+launch stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    check("flush+launch idle", 64'(stall_o), 64'd0);
    dcount = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done_o === 1'b1) dcount++;
    end
    check("flush+launch no done", 64'(dcount), 64'd0);
    check("flush+launch lo", 64'(lo_o), 64'd0);
    $display("flush+launch sequence: done pulses=%0d lo=%h", dcount, lo_o);

    run_vec(16, vecs[3]);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Multi-cycle controller for the HI/LO arithmetic class: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU.
- Sits in the execute stage beside the ALU. Accepts one operation per launch and sequences either a latency-counted multiplier or an iterative radix-2 restoring divider.
- Holds the pipeline via stall_o until the result is ready, then presents the new HI/LO pair with a one-cycle done pulse.

Parameters:
- MUL_LAT, 3, cycles spent in MUL state (legal range 1..15).
- DIV_ITERS, 32, restoring-divider iterations; fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- valid_i  in  1  execute-stage instruction is a multdiv op
- op_i  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
- a_i  in  32  rs value
- b_i  in  32  rt value
- hi_i  in  32  current HI, accumulate base
- lo_i  in  32  current LO, accumulate base
- flush_i  in  1  pipeline flush (exception/eret)
- stall_o  out  1  hold execute stage
- done_o  out  1  result valid, one-cycle pulse
- hi_o  out  32  new HI
- lo_o  out  32  new LO

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset: state=IDLE; all internal registers cleared; stall_o=0, done_o=0, hi_o=0, lo_o=0.
- States: IDLE, MUL, DIV, DONE.
- Launch (IDLE, valid_i=1, flush_i=0):
  - Latch op_i, a_i, b_i, hi_i, lo_i.
  - Go to MUL if op is not 2/3, else DIV.
  - Clear the iteration counter.
- MUL: stay MUL_LAT cycles, then DONE.
  - Product is 64-bit: signed for ops 0/4/6, unsigned for 1/5/7.
  - MULT/MULTU: {hi,lo}=product.
  - MADD*: {hi,lo}={hi_i,lo_i}+product, modulo 2^64.
  - MSUB*: {hi,lo}={hi_i,lo_i}-product, modulo 2^64.
- DIV: one quotient bit per cycle for DIV_ITERS cycles on operand magnitudes (abs for DIV, raw for DIVU), then DONE.
- DONE:
  - Sign correction: quotient negated iff DIV and sign(a)!=sign(b); remainder takes the sign of a.
  - lo=quotient, hi=remainder.
  - b==0: lo=32'hFFFF_FFFF and hi=a (as latched) for both DIV and DIVU; no exception raised.
  - done_o=1 for exactly one cycle, then IDLE.
- hi_o/lo_o: registered. Updated only on entry to DONE; hold their value otherwise, including after DONE.
- Latency, launch cycle = cycle 0:
  - multiply: done_o in cycle MUL_LAT+1 (cycle 4 at default).
  - divide: done_o in cycle 33.
- stall_o = (state==IDLE & valid_i & ~flush_i) | (state==MUL) | (state==DIV). It is low in DONE, so the stage advances on the done cycle.
- valid_i in MUL/DIV/DONE is ignored; there is no relaunch of the same instruction in DONE.
- flush_i in any state: next state IDLE, done_o stays 0, hi_o/lo_o unchanged, stall_o=0 that cycle. flush_i together with a launch condition in IDLE means no launch.
- reset mid-operation: same as the reset values above; any partial result is discarded.
- Signed corner: DIV 0x8000_0000 / 0xFFFF_FFFF gives lo=0x8000_0000, hi=0 (two's-complement wrap, no trap).

Optional Feature:
- Macro: MULTDIV_DIV_EARLY_OUT_EN.
- Defined: in the first DIV cycle, if |a|<|b| (magnitudes as above) or b==0, skip the iterations. Go to DONE next cycle with quotient=0 and remainder=a, or with the b==0 result. done_o then arrives in cycle 2.
- Undefined: every divide takes the full 33-cycle latency.

Test Plan:
- MULT a=0xFFFF_FFFE (-2), b=3, MUL_LAT=3 -> stall_o high cycles 0-3; done_o cycle 4; hi_o=0xFFFF_FFFF, lo_o=0xFFFF_FFFA.
- MADDU hi_i=0, lo_i=0xFFFF_FFFF, a=1, b=1 -> hi_o=1, lo_o=0; MSUB same operands with op 6 -> hi_o=0, lo_o=0xFFFF_FFFE.
- DIV a=-7 (0xFFFF_FFF9), b=2 -> done_o cycle 33; lo_o=0xFFFF_FFFD (-3), hi_o=0xFFFF_FFFF (-1).
- DIVU a=100, b=0 -> lo_o=0xFFFF_FFFF, hi_o=100. With MULTDIV_DIV_EARLY_OUT_EN: done_o cycle 2; without: cycle 33.
- DIVU a=10, b=3, flush_i pulsed at cycle 10 -> state IDLE cycle 11, no done_o, hi_o/lo_o keep prior values. Relaunch MULTU 5×6 -> lo_o=30, hi_o=0.
- reset asserted at cycle 5 of a DIV -> cycle 6: stall_o=0, done_o=0, hi_o=lo_o=0. valid_i held high during DONE -> exactly one done_o pulse.
